// File: rtl/clock_tick_sequencer_if.sv
// Tick/set request and time-of-day bundle between the sequencer and its neighbours.
// master drives the requests (prescaler/debouncers); slave is the sequencer.
interface clock_tick_sequencer_if;
  logic       tick_1hz;
  logic       set_req;
  logic [1:0] set_sel;
  logic       set_ack;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hour;
  logic       pm;
  logic       busy;
  logic       day_carry;
  logic       tick_overrun;

  modport master (
    output tick_1hz, set_req, set_sel,
    input  set_ack, sec, min, hour, pm, busy, day_carry, tick_overrun
  );

  modport slave (
    input  tick_1hz, set_req, set_sel,
    output set_ack, sec, min, hour, pm, busy, day_carry, tick_overrun
  );
endinterface

// File: rtl/clock_tick_sequencer.sv
// Time-of-day sequencer sharing one BCD incrementer between the 1 Hz cascade and the set path.
// Optional feature: define TIME_12H_EN for a 12 h clock with AM/PM flag.
module bcd_increment_16bit (
  input  logic [15:0] value,
  input  logic [15:0] bcd_max,
  output logic [15:0] result
);
  logic carry;

  always_comb begin
    result = value;
    carry  = 1'b1;
    if (value == bcd_max) begin
      result = 16'h0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (value[4*i +: 4] == 4'd9) begin
            result[4*i +: 4] = 4'd0;
          end else begin
            result[4*i +: 4] = value[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end
endmodule

// state | meaning
// IDLE  | waiting for a tick, a pending tick or a set request
// SEC   | increment seconds, cascade to MIN on wrap
// MIN   | increment minutes, cascade to HOUR on wrap
// HOUR  | increment hours, flag day_carry on day rollover
// SET   | increment the set_sel field once, no cascade
module clock_tick_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  clock_tick_sequencer_if.slave bus
);
`ifdef TIME_12H_EN
  localparam logic [15:0] HOUR_MAX = 16'h0012;
  localparam logic [7:0]  HOUR_RST = 8'h12;
`else
  localparam logic [15:0] HOUR_MAX = 16'h0023;
  localparam logic [7:0]  HOUR_RST = 8'h00;
`endif

  typedef enum logic [2:0] {IDLE, SEC, MIN, HOUR, SET} state_t;

  state_t      state, state_next;
  logic        pending, pending_next;
  logic        overrun_next;
  logic        day_carry_next;
  logic [1:0]  field;
  logic [15:0] operand, bcd_max, result;
  logic        wrap;
  logic [7:0]  hour_result;
  logic [7:0]  sec_q, min_q, hour_q;
  logic        set_ack_q, busy_q, day_carry_q, overrun_q;

  bcd_increment_16bit u_inc (
    .value   (operand),
    .bcd_max (bcd_max),
    .result  (result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    overrun_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.tick_1hz || pending) begin
          state_next   = SEC;
          pending_next = 1'b0;
        end else if (bus.set_req) begin
          state_next = SET;
        end
      end
      SEC:     state_next = wrap ? MIN : IDLE;
      MIN:     state_next = wrap ? HOUR : IDLE;
      HOUR:    state_next = IDLE;
      SET:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A tick that lands while busy is held once; a second one is lost.
    if (state != IDLE && bus.tick_1hz) begin
      if (pending) overrun_next = 1'b1;
      else         pending_next = 1'b1;
    end
  end

  // Field 3 means no write this cycle.
  always_comb begin
    unique case (state)
      SEC:     field = 2'd0;
      MIN:     field = 2'd1;
      HOUR:    field = 2'd2;
      SET:     field = bus.set_sel;
      default: field = 2'd3;
    endcase
    operand = 16'h0000;
    bcd_max = 16'h0059;
    unique case (field)
      2'd0:    operand = {8'h00, sec_q};
      2'd1:    operand = {8'h00, min_q};
      2'd2: begin
        operand = {8'h00, hour_q};
        bcd_max = HOUR_MAX;
      end
      default: operand = 16'h0000;
    endcase
  end

  assign wrap = (result == 16'h0000);

`ifdef TIME_12H_EN
  logic pm_q;

  // 12 h clocks have no hour zero: 12 rolls over to 1.
  assign hour_result    = wrap ? 8'h01 : result[7:0];
  assign day_carry_next = (state == HOUR) && pm_q && (hour_q == 8'h11);
  assign bus.pm         = pm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  pm_q <= 1'b0;
    else if (field == 2'd2 && hour_q == 8'h11) pm_q <= ~pm_q;
  end
`else
  assign hour_result    = result[7:0];
  assign day_carry_next = (state == HOUR) && wrap;
  assign bus.pm         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hour_q      <= HOUR_RST;
      set_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
      day_carry_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      set_ack_q   <= (state == SET);
      busy_q      <= (state_next != IDLE);
      day_carry_q <= day_carry_next;
      overrun_q   <= overrun_next;
      unique case (field)
        2'd0:    sec_q  <= result[7:0];
        2'd1:    min_q  <= result[7:0];
        2'd2:    hour_q <= hour_result;
        default: ;
      endcase
    end
  end

  assign bus.sec          = sec_q;
  assign bus.min          = min_q;
  assign bus.hour         = hour_q;
  assign bus.set_ack      = set_ack_q;
  assign bus.busy         = busy_q;
  assign bus.day_carry    = day_carry_q;
  assign bus.tick_overrun = overrun_q;
endmodule
